cmsdk_mcu_ahb_resp_mux: RTL

//  Data-phase return path of the MCU AHB fabric. The address decoder drives the
//  per-slave HSELs; this block registers them and steers the owning slave's

---
 rtl/cmsdk_mcu_ahb_resp_mux_pkg.sv | 24 ++
 rtl/cmsdk_mcu_ahb_def_slave.sv | 53 +++++
 rtl/cmsdk_mcu_ahb_resp_mux.sv | 76 +++++++
 3 files changed

// File: rtl/cmsdk_mcu_ahb_resp_mux_pkg.sv
// Shared AHB encodings for the MCU data-phase return path: transfer types,
// response codes and the default-slave state encoding.
package cmsdk_mcu_ahb_resp_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // NONSEQ and SEQ both carry bit 1; IDLE and BUSY must complete as OKAY.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/cmsdk_mcu_ahb_def_slave.sv
// Default slave for unmapped addresses: answers active transfers with a
// two-cycle ERROR response and everything else with a zero-wait OKAY.
module cmsdk_mcu_ahb_def_slave
    import cmsdk_mcu_ahb_resp_mux_pkg::*;
(
    input  logic      HCLK,
    input  logic      HRESETn,
    input  logic      HREADY,
    input  logic      trans_active_i,
    input  logic      DEFSLV_HSEL,
    output logic      ready_o,
    output logic      resp_o,
    output ds_state_e state_o
);

    ds_state_e state_q, state_d;
    logic      err_start;

    assign err_start = HREADY & DEFSLV_HSEL & trans_active_i;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b1;
        resp_o  = HRESP_OKAY;
        unique case (state_q)
            DS_IDLE: begin
                if (err_start) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                ready_o = 1'b0;
                resp_o  = HRESP_ERROR;
                state_d = DS_ERR2;
            end
            DS_ERR2: begin
                resp_o  = HRESP_ERROR;
                // A new unmapped address accepted here chains straight into another error.
                state_d = err_start ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/cmsdk_mcu_ahb_resp_mux.sv
// Data-phase response mux: registers the decoder selects at address-phase
// acceptance and AND-OR combines the owning slaves' responses for the CPU.
module cmsdk_mcu_ahb_resp_mux
    import cmsdk_mcu_ahb_resp_mux_pkg::*;
#(
    parameter int NUM_SLV = 8,
    parameter int DW      = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HREADY,
    input  logic [1:0]            HTRANS,
    input  logic [NUM_SLV-1:0]    HSEL_IN,
    input  logic                  DEFSLV_HSEL,
    input  logic [NUM_SLV-1:0]    HREADYOUT_IN,
    input  logic [NUM_SLV-1:0]    HRESP_IN,
    input  logic [NUM_SLV*DW-1:0] HRDATA_IN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DW-1:0]         HRDATA,
    output logic                  MULTI_SEL_ERR
);

    localparam logic [NUM_SLV:0] DSEL_ONE = 1;

    logic [NUM_SLV:0] dsel_q, dsel_d;
    logic             def_ready;
    logic             def_resp;
    ds_state_e        def_state;

    // dsel freezes during wait states so a new address phase cannot steal the data phase.
    assign dsel_d = HREADY ? {DEFSLV_HSEL, HSEL_IN} : dsel_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel_q <= '0;
        end else begin
            dsel_q <= dsel_d;
        end
    end

    cmsdk_mcu_ahb_def_slave u_def_slave (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .HREADY         (HREADY),
        .trans_active_i (htrans_active(HTRANS)),
        .DEFSLV_HSEL    (DEFSLV_HSEL),
        .ready_o        (def_ready),
        .resp_o         (def_resp),
        .state_o        (def_state)
    );

    logic [1:0] unused_dbg;
    assign unused_dbg = {HTRANS[0], ^def_state};

    always_comb begin
        HRDATA    = '0;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_q[i]) begin
                HRDATA    = HRDATA | HRDATA_IN[i*DW +: DW];
                HREADYOUT = HREADYOUT & HREADYOUT_IN[i];
                HRESP     = HRESP | HRESP_IN[i];
            end
        end
        // Default slave read data is always zero, so it only joins the ready/resp terms.
        if (dsel_q[NUM_SLV]) begin
            HREADYOUT = HREADYOUT & def_ready;
            HRESP     = HRESP | def_resp;
        end
    end

    assign MULTI_SEL_ERR = ((dsel_q & (dsel_q - DSEL_ONE)) != '0);

endmodule
